// File: rtl/clock_rate_detect.sv
// I2S format detector: counts LRCK edges and BCLKs-per-frame over a 1 ms gate
// window, classifies the stream and publishes a debounced 8-bit format code.
module clock_rate_detect #(
    parameter int CLK_HZ     = 100000000,
    parameter int LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk_in,
    input  logic       lrck_in,
    input  logic       dsd_in,
    output logic [7:0] data_out,
    output logic       next,
    output logic       locked
);
    localparam int GATE = CLK_HZ / 1000;
    localparam int GW   = $clog2(GATE);
    localparam int MW   = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
    localparam logic [MW-1:0] LOCK_M    = MW'(LOCK_COUNT);

    logic          bclk_meta_q, bclk_meta_d, bclk_sync_q, bclk_sync_d, bclk_prev_q, bclk_prev_d;
    logic          lrck_meta_q, lrck_meta_d, lrck_sync_q, lrck_sync_d, lrck_prev_q, lrck_prev_d;
    logic          dsd_meta_q, dsd_meta_d, dsd_sync_q, dsd_sync_d;
    logic [GW-1:0] gate_q, gate_d;
    logic [8:0]    e_cnt_q, e_cnt_d;
    logic [7:0]    bclk_cnt_q, bclk_cnt_d;
    logic          first_q, first_d, have_frame_q, have_frame_d;
    logic [7:0]    min_q, min_d, max_q, max_d;
    logic [7:0]    class_q, class_d;
    logic          class_vld_q, class_vld_d;
    logic [7:0]    cand_q, cand_d, data_q, data_d;
    logic [MW-1:0] match_q, match_d;
    logic          next_q, next_d;

    logic       bclk_rise, lrck_rise, boundary;
    logic [3:0] rate_v;
    logic [2:0] wmin_v, wmax_v;
    logic [7:0] win_class;

    // {valid, rate[2:0]} from LRCK edges per 1 ms window
    function automatic logic [3:0] rate_code(input logic [8:0] e);
        if      (e >= 9'd42  && e <= 9'd46)  rate_code = 4'b1000;
        else if (e >= 9'd47  && e <= 9'd50)  rate_code = 4'b1001;
        else if (e >= 9'd94  && e <= 9'd98)  rate_code = 4'b1010;
        else if (e >= 9'd126 && e <= 9'd130) rate_code = 4'b1011;
        else if (e >= 9'd174 && e <= 9'd179) rate_code = 4'b1100;
        else if (e >= 9'd190 && e <= 9'd194) rate_code = 4'b1101;
        else                                 rate_code = 4'b0000;
    endfunction

    // {valid, width[1:0]} from BCLKs per frame
    function automatic logic [2:0] width_code(input logic [7:0] f);
        if      (f >= 8'd31 && f <= 8'd33) width_code = 3'b100;
        else if (f >= 8'd47 && f <= 8'd49) width_code = 3'b101;
        else if (f >= 8'd63 && f <= 8'd65) width_code = 3'b110;
        else                               width_code = 3'b000;
    endfunction

    assign bclk_rise = bclk_sync_q & ~bclk_prev_q;
    assign lrck_rise = lrck_sync_q & ~lrck_prev_q;
    assign boundary  = (gate_q == GATE_LAST);

    always_comb begin
        bclk_meta_d = bclk_in;
        bclk_sync_d = bclk_meta_q;
        bclk_prev_d = bclk_sync_q;
        lrck_meta_d = lrck_in;
        lrck_sync_d = lrck_meta_q;
        lrck_prev_d = lrck_sync_q;
        dsd_meta_d  = dsd_in;
        dsd_sync_d  = dsd_meta_q;
    end

    always_comb begin
        rate_v = rate_code(e_cnt_q);
        wmin_v = width_code(min_q);
        wmax_v = width_code(max_q);
        if (dsd_sync_q)
            win_class = 8'h80;
        else if (rate_v[3] && have_frame_q && wmin_v[2] && (wmin_v == wmax_v))
            win_class = {1'b0, wmin_v[1:0], 2'b00, rate_v[2:0]};
        else
            win_class = 8'hFF;
    end

    // Edges seen on the boundary cycle open the new window; the frame that
    // straddles the boundary is never folded into min/max.
    always_comb begin
        gate_d       = boundary ? '0 : gate_q + GW'(1);
        e_cnt_d      = e_cnt_q;
        bclk_cnt_d   = bclk_cnt_q;
        first_d      = first_q;
        have_frame_d = have_frame_q;
        min_d        = min_q;
        max_d        = max_q;
        if (bclk_rise && bclk_cnt_q != 8'hFF)
            bclk_cnt_d = bclk_cnt_q + 8'd1;
        if (lrck_rise)
            bclk_cnt_d = {7'b0, bclk_rise};
        if (boundary) begin
            e_cnt_d      = {8'b0, lrck_rise};
            first_d      = lrck_rise;
            have_frame_d = 1'b0;
            min_d        = 8'hFF;
            max_d        = 8'h00;
        end else if (lrck_rise) begin
            if (e_cnt_q != 9'h1FF)
                e_cnt_d = e_cnt_q + 9'd1;
            first_d = 1'b1;
            if (first_q) begin
                have_frame_d = 1'b1;
                if (bclk_cnt_q < min_q) min_d = bclk_cnt_q;
                if (bclk_cnt_q > max_q) max_d = bclk_cnt_q;
            end
        end
        class_vld_d = boundary;
        class_d     = boundary ? win_class : class_q;
    end

    // next is a one-cycle strobe that coincides with the new data_out value;
    // there is no back-pressure, so the consumer samples data_out while next=1.
    always_comb begin
        cand_d  = cand_q;
        match_d = match_q;
        data_d  = data_q;
        next_d  = 1'b0;
        if (class_vld_q) begin
            if (class_q == cand_q) begin
                if (match_q != LOCK_M)
                    match_d = match_q + MW'(1);
            end else begin
                cand_d  = class_q;
                match_d = MW'(1);
            end
            if (match_d == LOCK_M && cand_d != data_q) begin
                data_d = cand_d;
                next_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_meta_q  <= 1'b0;
            bclk_sync_q  <= 1'b0;
            bclk_prev_q  <= 1'b0;
            lrck_meta_q  <= 1'b0;
            lrck_sync_q  <= 1'b0;
            lrck_prev_q  <= 1'b0;
            dsd_meta_q   <= 1'b0;
            dsd_sync_q   <= 1'b0;
            gate_q       <= '0;
            e_cnt_q      <= '0;
            bclk_cnt_q   <= '0;
            first_q      <= 1'b0;
            have_frame_q <= 1'b0;
            min_q        <= 8'hFF;
            max_q        <= 8'h00;
            class_q      <= 8'hFF;
            class_vld_q  <= 1'b0;
            cand_q       <= 8'hFF;
            match_q      <= '0;
            data_q       <= 8'hFF;
            next_q       <= 1'b0;
        end else begin
            bclk_meta_q  <= bclk_meta_d;
            bclk_sync_q  <= bclk_sync_d;
            bclk_prev_q  <= bclk_prev_d;
            lrck_meta_q  <= lrck_meta_d;
            lrck_sync_q  <= lrck_sync_d;
            lrck_prev_q  <= lrck_prev_d;
            dsd_meta_q   <= dsd_meta_d;
            dsd_sync_q   <= dsd_sync_d;
            gate_q       <= gate_d;
            e_cnt_q      <= e_cnt_d;
            bclk_cnt_q   <= bclk_cnt_d;
            first_q      <= first_d;
            have_frame_q <= have_frame_d;
            min_q        <= min_d;
            max_q        <= max_d;
            class_q      <= class_d;
            class_vld_q  <= class_vld_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            data_q       <= data_d;
            next_q       <= next_d;
        end
    end

    assign data_out = data_q;
    assign next     = next_q;
    assign locked   = (data_q != 8'hFF);
endmodule

// File: tb/tb_clock_rate_detect.sv
// Randomized bench for clock_rate_detect: synthesizes one gate window of I2S
// traffic at a time, predicts the format code from the rate/width tables.
module tb_clock_rate_detect;
    localparam int CLK_HZ     = 6400000;
    localparam int GATE       = CLK_HZ / 1000;
    localparam int LOCK_COUNT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bclk_in = 1'b0;
    logic       lrck_in = 1'b0;
    logic       dsd_in = 1'b0;
    logic [7:0] data_out;
    logic       next;
    logic       locked;

    clock_rate_detect #(.CLK_HZ(CLK_HZ), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bclk_in  (bclk_in),
        .lrck_in  (lrck_in),
        .dsd_in   (dsd_in),
        .data_out (data_out),
        .next     (next),
        .locked   (locked)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hist[$];
    logic [7:0] model_out = 8'hFF;
    logic [7:0] mon_exp;

    logic stim_b[GATE];
    logic stim_l[GATE];
    logic stim_d;
    int   win_e;
    int   win_w[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int band(input int f);
        if (f >= 31 && f <= 33) return 0;
        if (f >= 47 && f <= 49) return 1;
        if (f >= 63 && f <= 65) return 2;
        return -1;
    endfunction

    function automatic logic [7:0] classify(input int e, input int nfr, input int fmin,
                                            input int fmax, input logic dsd);
        int r;
        if (dsd) return 8'h80;
        if      (e >= 42  && e <= 46)  r = 0;
        else if (e >= 47  && e <= 50)  r = 1;
        else if (e >= 94  && e <= 98)  r = 2;
        else if (e >= 126 && e <= 130) r = 3;
        else if (e >= 174 && e <= 179) r = 4;
        else if (e >= 190 && e <= 194) r = 5;
        else return 8'hFF;
        if (nfr < 1) return 8'hFF;
        if (band(fmin) < 0 || band(fmin) != band(fmax)) return 8'hFF;
        return 8'(band(fmin) * 32 + r);
    endfunction

    // Output follows the class once the last LOCK_COUNT windows all agree.
    task automatic model_window();
        int         nfr;
        int         fmin;
        int         fmax;
        logic [7:0] cls;
        bit         same;
        nfr  = (win_e > 0) ? win_e - 1 : 0;
        fmin = 1000;
        fmax = 0;
        for (int i = 0; i < nfr; i++) begin
            if (win_w[i] < fmin) fmin = win_w[i];
            if (win_w[i] > fmax) fmax = win_w[i];
        end
        cls = classify(win_e, nfr, fmin, fmax, stim_d);
        hist.push_back(cls);
        if (hist.size() > LOCK_COUNT) void'(hist.pop_front());
        if (hist.size() == LOCK_COUNT) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
            if (same && cls != model_out) begin
                model_out = cls;
                exp_q.push_back(cls);
            end
        end
    endtask

    // ---------------- stimulus builders / driver ----------------
    task automatic clear_stim();
        for (int i = 0; i < GATE; i++) begin
            stim_b[i] = 1'b0;
            stim_l[i] = 1'b0;
        end
        win_w.delete();
        win_e  = 0;
        stim_d = 1'b0;
    endtask

    // e LRCK frames, widths random in [fmin,fmax]; frame jit_idx is 40 BCLKs.
    task automatic build_pcm(input int e, input int fmin, input int fmax, input int jit_idx);
        int t;
        clear_stim();
        win_e = e;
        t = $urandom_range(40, 8);
        for (int i = 0; i < e; i++) begin
            int f;
            f = (i == jit_idx) ? 40 : $urandom_range(fmax, fmin);
            win_w.push_back(f);
            for (int b = 0; b < f; b++) begin
                stim_l[t]     = (b < (f + 1) / 2);
                stim_l[t + 1] = (b < (f + 1) / 2);
                stim_b[t]     = 1'b0;
                stim_b[t + 1] = 1'b1;
                t += 2;
            end
        end
    endtask

    task automatic build_dsd();
        clear_stim();
        for (int i = 0; i < GATE; i++) stim_b[i] = (i % 2 == 1);
        stim_d = 1'b1;
    endtask

    task automatic run_window(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            bclk_in = stim_b[t];
            lrck_in = stim_l[t];
            dsd_in  = stim_d;
            if (t == 1) begin
                check8("window_data_out", data_out, model_out);
                check8("window_locked", {7'b0, locked}, {7'b0, model_out != 8'hFF});
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        bclk_in = 1'b0;
        lrck_in = 1'b0;
        dsd_in  = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_out = 8'hFF;
        hist.delete();
        check8("reset_data_out", data_out, 8'hFF);
        check8("reset_locked", {7'b0, locked}, 8'h00);
        check8("reset_next", {7'b0, next}, 8'h00);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (next === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_next: data_out=%02h, expected no change at %0t",
                         data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_out !== mon_exp || locked !== (mon_exp != 8'hFF)) begin
                    errors++;
                    $display("FAIL next_data_out: got %02h locked=%0b, expected %02h at %0t",
                             data_out, locked, mon_exp, $time);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int e;
        do_reset(3);

        repeat (2) begin
            build_pcm($urandom_range(48, 47), 63, 64, -1);
            run_window(GATE);
            model_window();
        end

        e = $urandom_range(48, 47);
        build_pcm(e, 63, 64, $urandom_range(e - 2, 0));
        run_window(GATE);
        model_window();

        repeat (2) begin
            build_pcm($urandom_range(96, 94), 31, 32, -1);
            run_window(GATE);
            model_window();
        end

        e = $urandom_range(45, 44);
        build_pcm(e, 47, 49, -1);
        run_window(GATE);
        model_window();
        build_pcm(89 - e, 47, 49, -1);
        run_window(GATE);
        model_window();

        build_pcm(e, 47, 49, -1);
        run_window($urandom_range(4500, 1500));
        do_reset(1);

        repeat (2) begin
            build_dsd();
            run_window(GATE);
            model_window();
        end

        repeat (2) begin
            clear_stim();
            run_window(GATE);
            model_window();
        end

        repeat (4) @(negedge clk);
        check8("final_data_out", data_out, 8'hFF);
        check8("final_locked", {7'b0, locked}, 8'h00);
        check8("pending_next_count", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: time limit reached, expected sequence completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
